pwm_audio_multi: RTL and testbench

//  N-channel PWM audio DAC. Accepts signed multi-channel frames over a valid/ready handshake.

---
 rtl/pwm_audio_multi.sv | 113 +++++++++++
 tb/tb_pwm_audio_multi.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_audio_multi.sv
// pwm_audio_multi: N-channel PWM audio DAC.
//   Signed multi-channel frames arrive over a valid/ready handshake into a
//   one-deep shadow buffer. At the end of each PWM period the buffered frame is
//   scaled by the volume, offset to unsigned, and becomes the new duty level.
//   This keeps a duty cycle from ever changing mid-period. If a period ends
//   with the shadow empty, the levels are held and underrun_out pulses.
// Ports:
//   clk_in        system clock
//   rst_in        synchronous active-high reset
//   enable_in     run the PWM counter; low holds the counter at 0 and the outputs low
//   sample_in     frame, channel i at [i*SAMPLE_W +: SAMPLE_W], two's complement
//   sample_valid  frame valid
//   sample_ready  shadow buffer empty
//   volume_in     gain (volume_in+1)/2**VOL_W, sampled at the period boundary
//   mute_in       force the midpoint level, sampled at the period boundary
//   pwm_out       registered PWM output per channel
//   underrun_out  one-cycle pulse when a period ends with no frame buffered
module pwm_audio_multi #(
  parameter int NUM_CH   = 2,
  parameter int SAMPLE_W = 8,
  parameter int VOL_W    = 4
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       enable_in,
  input  logic [NUM_CH*SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       sample_ready,
  input  logic [VOL_W-1:0]           volume_in,
  input  logic                       mute_in,
  output logic [NUM_CH-1:0]          pwm_out,
  output logic                       underrun_out
);

  localparam int P_W = SAMPLE_W + VOL_W + 1;
  localparam logic [SAMPLE_W-1:0] MID     = {1'b1, {(SAMPLE_W-1){1'b0}}};
  localparam logic [SAMPLE_W-1:0] CNT_MAX = {SAMPLE_W{1'b1}};

  // Floor of s*(vol+1)/2**VOL_W; the magnitude never exceeds |s|, so the
  // result always fits back into SAMPLE_W bits without saturation.
  function automatic logic [SAMPLE_W-1:0] scale(input logic [SAMPLE_W-1:0] s,
                                                input logic [VOL_W-1:0]    vol);
    logic signed [P_W-1:0] s_ext;
    logic signed [P_W-1:0] g_ext;
    logic signed [P_W-1:0] p;
    s_ext = {{(P_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    g_ext = {{(P_W-VOL_W){1'b0}}, vol} + {{(P_W-1){1'b0}}, 1'b1};
    p     = s_ext * g_ext;
    p     = p >>> VOL_W;
    return p[SAMPLE_W-1:0];
  endfunction

  // Two's complement to offset binary: flipping the sign bit adds 2**(SAMPLE_W-1).
  function automatic logic [SAMPLE_W-1:0] offset(input logic [SAMPLE_W-1:0] x);
    return {~x[SAMPLE_W-1], x[SAMPLE_W-2:0]};
  endfunction

  logic [SAMPLE_W-1:0]        count_p0;
  logic                       shadow_full;
  logic [NUM_CH*SAMPLE_W-1:0] shadow;
  logic [SAMPLE_W-1:0]        level [NUM_CH];
  logic                       load;
  logic                       accept;

  assign sample_ready = ~shadow_full;
  assign accept       = sample_valid & ~shadow_full;
  assign load         = enable_in & (count_p0 == CNT_MAX);

  // Shadow data carries no reset; shadow_full alone says whether it is live.
  always_ff @(posedge clk_in) begin
    if (accept) begin
      shadow <= sample_in;
    end
  end

  // Stage 0: period counter, shadow state and period-boundary level load
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      count_p0     <= '0;
      shadow_full  <= 1'b0;
      underrun_out <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
        level[i] <= MID;
      end
    end else begin
      count_p0     <= enable_in ? count_p0 + 1'b1 : '0;
      underrun_out <= load & ~shadow_full;
      // A load can only consume a full shadow and an accept needs an empty
      // one, so the two branches never compete for shadow_full.
      if (load && shadow_full) begin
        shadow_full <= 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
          level[i] <= mute_in ? MID
                              : offset(scale(shadow[i*SAMPLE_W +: SAMPLE_W], volume_in));
        end
      end else if (accept) begin
        shadow_full <= 1'b1;
      end
    end
  end

  // Stage 1: PWM compare, one cycle behind the counter
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pwm_out <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        pwm_out[i] <= enable_in & (count_p0 < level[i]);
      end
    end
  end

endmodule

// File: tb/tb_pwm_audio_multi.sv
module tb_pwm_audio_multi;
  localparam int NUM_CH   = 2;
  localparam int SAMPLE_W = 8;
  localparam int VOL_W    = 4;
  localparam int PER      = 256;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        enable_in = 1'b0;
  logic [15:0] sample_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic [3:0]  volume_in = '0;
  logic        mute_in = 1'b0;
  logic [1:0]  pwm_out;
  logic        underrun_out;

  always #5 clk_in = ~clk_in;

  pwm_audio_multi #(.NUM_CH(NUM_CH), .SAMPLE_W(SAMPLE_W), .VOL_W(VOL_W)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .sample_in(sample_in), .sample_valid(sample_valid), .sample_ready(sample_ready),
    .volume_in(volume_in), .mute_in(mute_in),
    .pwm_out(pwm_out), .underrun_out(underrun_out)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference level: floor(s*(v+1)/16) shifted to unsigned by adding half scale.
  function automatic int ref_level(input int s, input int v, input bit m);
    int p, q;
    if (m) return PER / 2;
    p = s * (v + 1);
    q = p / 16;
    if (p < 0 && (p % 16) != 0) q = q - 1;
    return q + PER / 2;
  endfunction

  // Behavioural model: period position, pending frame, current duty levels.
  int     m_t;
  int     m_lvl [2];
  int     m_sh  [2];
  bit     m_full, m_und, m_acc, m_live = 1'b0;
  bit     m_ld, m_take;
  bit [1:0] m_pwm;

  always @(posedge clk_in) begin
    if (rst_in) begin
      m_t = 0; m_full = 0; m_und = 0; m_acc = 0; m_pwm = '0; m_live = 1;
      m_lvl[0] = PER / 2; m_lvl[1] = PER / 2;
    end else begin
      m_take = sample_valid && !m_full;
      m_ld   = enable_in && (m_t == PER - 1);
      for (int i = 0; i < 2; i++) m_pwm[i] = enable_in && (m_t < m_lvl[i]);
      m_und = m_ld && !m_full;
      if (m_ld && m_full) begin
        for (int i = 0; i < 2; i++) m_lvl[i] = ref_level(m_sh[i], int'(volume_in), mute_in);
        m_full = 0;
      end else if (m_take) begin
        m_sh[0] = int'($signed(sample_in[7:0]));
        m_sh[1] = int'($signed(sample_in[15:8]));
        m_full  = 1;
      end
      m_acc = m_take;
      m_t   = enable_in ? (m_t + 1) % PER : 0;
    end
  end

  always @(negedge clk_in) begin
    if (m_live) begin
      chk("pwm_ch0", pwm_out[0], m_pwm[0]);
      chk("pwm_ch1", pwm_out[1], m_pwm[1]);
      chk("underrun", underrun_out, m_und);
      chk("ready", sample_ready, !m_full);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic send(input int l, input int r);
    int k = 0;
    sample_in    = {8'(r), 8'(l)};
    sample_valid = 1'b1;
    do begin
      tick();
      k++;
    end while (!m_acc && k < 2000);
    chk("send_accept", m_acc, 1);
    sample_valid = 1'b0;
  endtask

  task automatic wait_t(input int target);
    int k = 0;
    while (m_t != target && k < 2000) begin
      tick();
      k++;
    end
    chk("wait_count", m_t, target);
  endtask

  // Measures one whole period starting at the next wrap: underrun/ready seen at
  // count 0, then high cycles per channel for compares at counts 0..255.
  task automatic measure(output int h0, output int h1, output int u, output int rdy);
    tick();
    wait_t(0);
    @(negedge clk_in);
    u = underrun_out; rdy = sample_ready; h0 = 0; h1 = 0;
    for (int i = 0; i < PER; i++) begin
      tick();
      @(negedge clk_in);
      h0 += pwm_out[0];
      h1 += pwm_out[1];
    end
  endtask

  initial begin
    int h0, h1, u, rdy;
    tick(); tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("reset_ready", sample_ready, 1);
    chk("reset_pwm", pwm_out, 0);
    chk("reset_underrun", underrun_out, 0);

    // Model pins
    chk("ref_v7_p64", ref_level(64, 7, 0), 160);
    chk("ref_v0_m1", ref_level(-1, 0, 0), 127);
    chk("ref_v15_m128", ref_level(-128, 15, 0), 0);
    chk("ref_mute", ref_level(127, 15, 1), 128);

    // Idle: midpoint duty, underrun every period
    enable_in = 1'b1;
    measure(h0, h1, u, rdy);
    chk("idle_h0", h0, 128); chk("idle_h1", h1, 128); chk("idle_und", u, 1);

    // Full-scale frame
    volume_in = 4'd15;
    send(8'h7F, 8'h80);
    measure(h0, h1, u, rdy);
    chk("full_h0", h0, 255); chk("full_h1", h1, 0); chk("full_und", u, 0); chk("full_rdy", rdy, 1);
    measure(h0, h1, u, rdy);
    chk("hold_h0", h0, 255); chk("hold_h1", h1, 0); chk("hold_und", u, 1);

    // Volume scaling
    volume_in = 4'd7;
    send(64, -128);
    measure(h0, h1, u, rdy);
    chk("vol7_h0", h0, 160); chk("vol7_h1", h1, 64);

    // Mute
    mute_in = 1'b1;
    send(127, 5);
    measure(h0, h1, u, rdy);
    chk("mute_h0", h0, 128); chk("mute_h1", h1, 128); chk("mute_und", u, 0); chk("mute_rdy", rdy, 1);
    mute_in = 1'b0;

    // Second frame stalls until the load frees the shadow
    volume_in = 4'd15;
    send(10, 20);
    sample_in = {8'd40, 8'd30};
    sample_valid = 1'b1;
    @(negedge clk_in);
    chk("stall_ready", sample_ready, 0);
    send(30, 40);
    chk("stall_accept_count", m_t, 1);
    measure(h0, h1, u, rdy);
    chk("stall_h0", h0, 158); chk("stall_h1", h1, 168); chk("stall_und", u, 0);

    // Reset mid-period with a full shadow drops the frame
    send(100, -100);
    wait_t(100);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    @(negedge clk_in);
    chk("midrst_ready", sample_ready, 1);
    chk("midrst_pwm", pwm_out, 0);
    measure(h0, h1, u, rdy);
    chk("midrst_h0", h0, 128); chk("midrst_h1", h1, 128); chk("midrst_und", u, 1);

    // Disable mid-period
    wait_t(50);
    enable_in = 1'b0;
    tick();
    @(negedge clk_in);
    chk("disable_pwm", pwm_out, 0);
    enable_in = 1'b1;

    // Randomized traffic
    for (int c = 0; c < 8000; c++) begin
      rst_in = ($urandom_range(0, 2999) == 0);
      if (enable_in) begin
        if ($urandom_range(0, 499) == 0) enable_in = 1'b0;
      end else if ($urandom_range(0, 49) == 0) begin
        enable_in = 1'b1;
      end
      if (!(sample_valid && !m_acc)) begin
        sample_valid = ($urandom_range(0, 199) == 0);
        sample_in    = 16'($urandom);
      end
      volume_in = 4'($urandom);
      mute_in   = ($urandom_range(0, 7) == 0);
      tick();
    end
    rst_in = 1'b0;
    sample_valid = 1'b0;
    tick();
    @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
